// File: rtl/cdb_writeback_arbiter.sv
// Writeback stage: per-FU result FIFOs, round-robin arbitrated onto registered CDB ports.
// Flush drops all buffered and in-flight results; rr pointer and stall counter survive it.
module cdb_writeback_arbiter #(
    parameter int unsigned NUM_FU         = 5,
    parameter int unsigned NUM_CDB        = 2,
    parameter int unsigned DEPTH          = 2,
    parameter int unsigned ROB_ADDR_WIDTH = 5,
    parameter int unsigned PHYS_REG_BITS  = 6,
    parameter int unsigned ARCH_REG_BITS  = 5,
    localparam int unsigned SRC_W         = $clog2(NUM_FU)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [NUM_FU-1:0]                 fu_valid,
    output logic [NUM_FU-1:0]                 fu_ready,
    input  logic [NUM_FU*ROB_ADDR_WIDTH-1:0]  fu_rob_idx,
    input  logic [NUM_FU*PHYS_REG_BITS-1:0]   fu_pd,
    input  logic [NUM_FU*ARCH_REG_BITS-1:0]   fu_rd,
    input  logic [NUM_FU*32-1:0]              fu_rd_v,
    output logic [NUM_CDB-1:0]                cdb_valid,
    output logic [NUM_CDB*ROB_ADDR_WIDTH-1:0] cdb_rob_idx,
    output logic [NUM_CDB*PHYS_REG_BITS-1:0]  cdb_pd,
    output logic [NUM_CDB*ARCH_REG_BITS-1:0]  cdb_rd,
    output logic [NUM_CDB*32-1:0]             cdb_rd_v,
    output logic [NUM_CDB*SRC_W-1:0]          cdb_src,
    output logic [31:0]                       stall_cnt
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned EntW = ROB_ADDR_WIDTH + PHYS_REG_BITS + ARCH_REG_BITS + 32;

    logic [EntW-1:0]    mem_q     [NUM_FU][DEPTH];
    logic [PtrW-1:0]    wr_ptr_q  [NUM_FU];
    logic [PtrW-1:0]    rd_ptr_q  [NUM_FU];
    logic [CntW-1:0]    count_q   [NUM_FU];
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [31:0]        stall_cnt_q;
    logic [NUM_CDB-1:0] cdb_valid_q;
    logic [EntW-1:0]    cdb_ent_q [NUM_CDB];
    logic [SRC_W-1:0]   cdb_src_q [NUM_CDB];

    logic [NUM_FU-1:0]  nonempty, grant, push;
    logic [EntW-1:0]    fu_ent    [NUM_FU];
    logic [NUM_CDB-1:0] port_valid;
    logic [SRC_W-1:0]   port_ch   [NUM_CDB];
    logic               stall_evt;

    // Ready comes from the registered count only: a full FIFO stays not-ready while it pops.
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            fu_ent[i]   = {fu_rob_idx[i*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH],
                           fu_pd[i*PHYS_REG_BITS +: PHYS_REG_BITS],
                           fu_rd[i*ARCH_REG_BITS +: ARCH_REG_BITS],
                           fu_rd_v[i*32 +: 32]};
            nonempty[i] = (count_q[i] != '0);
            fu_ready[i] = (count_q[i] != CntW'(DEPTH)) && !rst;
            push[i]     = fu_valid[i] && fu_ready[i] && !flush;
        end
    end

    always_comb begin
        int unsigned ch;
        int unsigned ngrant;
        ch         = 0;
        ngrant     = 0;
        grant      = '0;
        port_valid = '0;
        rr_ptr_d   = rr_ptr_q;
        for (int j = 0; j < NUM_CDB; j++) begin
            port_ch[j] = '0;
        end
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            ch = 32'(rr_ptr_q) + k;
            if (ch >= NUM_FU) begin
                ch = ch - NUM_FU;
            end
            if (!flush && nonempty[ch] && (ngrant < NUM_CDB)) begin
                grant[ch] = 1'b1;
                for (int j = 0; j < NUM_CDB; j++) begin
                    if (32'(j) == ngrant) begin
                        port_valid[j] = 1'b1;
                        port_ch[j]    = SRC_W'(ch);
                    end
                end
                rr_ptr_d = (ch == NUM_FU - 1) ? '0 : SRC_W'(ch + 1);
                ngrant   = ngrant + 1;
            end
        end
        stall_evt = !flush && |(nonempty & ~grant);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= fu_ent[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FU; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_ptr_q    <= '0;
            stall_cnt_q <= '0;
            cdb_valid_q <= '0;
            for (int j = 0; j < NUM_CDB; j++) begin
                cdb_ent_q[j] <= '0;
                cdb_src_q[j] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (stall_evt && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (flush) begin
                    wr_ptr_q[i] <= '0;
                    rd_ptr_q[i] <= '0;
                    count_q[i]  <= '0;
                end else begin
                    if (push[i]) begin
                        wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
                    end
                    if (grant[i]) begin
                        rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
                    end
                    if (push[i] && !grant[i]) begin
                        count_q[i] <= count_q[i] + CntW'(1);
                    end else if (!push[i] && grant[i]) begin
                        count_q[i] <= count_q[i] - CntW'(1);
                    end
                end
            end
            for (int j = 0; j < NUM_CDB; j++) begin
                if (port_valid[j]) begin
                    cdb_valid_q[j] <= 1'b1;
                    cdb_ent_q[j]   <= mem_q[port_ch[j]][rd_ptr_q[port_ch[j]]];
                    cdb_src_q[j]   <= port_ch[j];
                end else begin
                    cdb_valid_q[j] <= 1'b0;
                    cdb_ent_q[j]   <= '0;
                    cdb_src_q[j]   <= '0;
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_CDB; j++) begin
            cdb_valid[j] = cdb_valid_q[j] && !flush;
            cdb_rob_idx[j*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH] =
                cdb_ent_q[j][EntW-1 -: ROB_ADDR_WIDTH];
            cdb_pd[j*PHYS_REG_BITS +: PHYS_REG_BITS] =
                cdb_ent_q[j][EntW-ROB_ADDR_WIDTH-1 -: PHYS_REG_BITS];
            cdb_rd[j*ARCH_REG_BITS +: ARCH_REG_BITS] = cdb_ent_q[j][32 +: ARCH_REG_BITS];
            cdb_rd_v[j*32 +: 32]           = cdb_ent_q[j][31:0];
            cdb_src[j*SRC_W +: SRC_W]      = cdb_src_q[j];
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Bench for cdb_writeback_arbiter: per-channel scoreboard queues plus directed timing checks.
module tb_cdb_writeback_arbiter;
    localparam int unsigned NUM_FU  = 5;
    localparam int unsigned NUM_CDB = 2;
    localparam int unsigned DEPTH   = 2;
    localparam int unsigned ROBW    = 5;
    localparam int unsigned PDW     = 6;
    localparam int unsigned RDW     = 5;
    localparam int unsigned SRCW    = $clog2(NUM_FU);
    localparam int unsigned ENTW    = ROBW + PDW + RDW + 32;

    logic                       clk;
    logic                       rst;
    logic                       flush;
    logic [NUM_FU-1:0]          fu_valid;
    logic [NUM_FU-1:0]          fu_ready;
    logic [NUM_FU*ROBW-1:0]     fu_rob_idx;
    logic [NUM_FU*PDW-1:0]      fu_pd;
    logic [NUM_FU*RDW-1:0]      fu_rd;
    logic [NUM_FU*32-1:0]       fu_rd_v;
    logic [NUM_CDB-1:0]         cdb_valid;
    logic [NUM_CDB*ROBW-1:0]    cdb_rob_idx;
    logic [NUM_CDB*PDW-1:0]     cdb_pd;
    logic [NUM_CDB*RDW-1:0]     cdb_rd;
    logic [NUM_CDB*32-1:0]      cdb_rd_v;
    logic [NUM_CDB*SRCW-1:0]    cdb_src;
    logic [31:0]                stall_cnt;

    cdb_writeback_arbiter #(
        .NUM_FU        (NUM_FU),
        .NUM_CDB       (NUM_CDB),
        .DEPTH         (DEPTH),
        .ROB_ADDR_WIDTH(ROBW),
        .PHYS_REG_BITS (PDW),
        .ARCH_REG_BITS (RDW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fu_valid   (fu_valid),
        .fu_ready   (fu_ready),
        .fu_rob_idx (fu_rob_idx),
        .fu_pd      (fu_pd),
        .fu_rd      (fu_rd),
        .fu_rd_v    (fu_rd_v),
        .cdb_valid  (cdb_valid),
        .cdb_rob_idx(cdb_rob_idx),
        .cdb_pd     (cdb_pd),
        .cdb_rd     (cdb_rd),
        .cdb_rd_v   (cdb_rd_v),
        .cdb_src    (cdb_src),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [ENTW-1:0]       sbq [NUM_FU][$];
    logic [ENTW-1:0]       in_ent [NUM_FU];
    logic [NUM_FU-1:0]     in_valid;
    logic [NUM_FU-1:0]     auto_en;
    logic [NUM_FU-1:0]     acc_q;
    int unsigned           auto_seq [NUM_FU];
    int                    n_checks;
    int                    n_errors;
    logic [NUM_CDB-1:0]    obs_valid;
    logic [NUM_CDB*SRCW-1:0] obs_src;
    logic [31:0]           obs_stall;
    logic [NUM_FU-1:0]     obs_ready;
    logic [ENTW-1:0]       obs_p0;
    logic                  fair_on;
    logic                  ch1_seen;
    int                    gap;
    int                    max_gap;
    int                    ch1_hits;
    logic [ENTW-1:0]       t1_ent;
    logic [ENTW-1:0]       t4_vals [3];
    logic [3:0]            rdy_hist;
    logic [31:0]           base;
    int                    idx;
    int                    total;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", tag, got, exp);
        end
    endtask

    function automatic logic [ENTW-1:0] auto_ent(input int unsigned ch, input int unsigned seq);
        logic [ROBW-1:0] rob;
        logic [PDW-1:0]  pd;
        logic [RDW-1:0]  rd;
        logic [31:0]     v;
        rob = ROBW'(seq);
        pd  = PDW'(seq * 3 + ch);
        rd  = RDW'(ch + seq);
        v   = {8'(ch), 24'(seq)};
        return {rob, pd, rd, v};
    endfunction

    function automatic logic [63:0] src_pair(input int unsigned p1, input int unsigned p0);
        return 64'((p1 << SRCW) | p0);
    endfunction

    function automatic logic [ENTW-1:0] port_ent(input int unsigned j);
        return {cdb_rob_idx[j*ROBW +: ROBW], cdb_pd[j*PDW +: PDW],
                cdb_rd[j*RDW +: RDW], cdb_rd_v[j*32 +: 32]};
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_FU; i++) begin
            fu_valid[i]               = in_valid[i];
            fu_rob_idx[i*ROBW +: ROBW] = in_ent[i][ENTW-1 -: ROBW];
            fu_pd[i*PDW +: PDW]       = in_ent[i][ENTW-ROBW-1 -: PDW];
            fu_rd[i*RDW +: RDW]       = in_ent[i][32 +: RDW];
            fu_rd_v[i*32 +: 32]       = in_ent[i][31:0];
        end
    endtask

    task automatic monitor();
        logic [SRCW-1:0]    src;
        logic [NUM_CDB-1:0] vplus;
        logic [ENTW-1:0]    exp_ent;
        logic               ch1_hit;
        obs_valid = cdb_valid;
        obs_src   = cdb_src;
        obs_stall = stall_cnt;
        obs_ready = fu_ready;
        obs_p0    = port_ent(0);
        ch1_hit   = 1'b0;
        vplus     = cdb_valid + NUM_CDB'(1);
        // Grants fill ports from port 0 upward.
        check_eq("valid_packed", (cdb_valid & vplus) == '0, 1'b1);
        if (flush) begin
            check_eq("flush_valid", cdb_valid, 0);
        end
        for (int j = 0; j < NUM_CDB; j++) begin
            if (cdb_valid[j]) begin
                src = cdb_src[j*SRCW +: SRCW];
                check_eq("src_range", src < NUM_FU, 1'b1);
                if (src < NUM_FU) begin
                    check_eq("sb_pending", sbq[src].size() > 0, 1'b1);
                    if (sbq[src].size() > 0) begin
                        exp_ent = sbq[src].pop_front();
                        check_eq("cdb_data", port_ent(j), exp_ent);
                    end
                    if (src == 1) ch1_hit = 1'b1;
                end
            end else if (!flush) begin
                check_eq("idle_zero", {port_ent(j), cdb_src[j*SRCW +: SRCW]}, 0);
            end
        end
        if (!flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                check_eq("fu_ready", fu_ready[i], !rst && (sbq[i].size() < DEPTH));
            end
        end
        if (fair_on) begin
            gap++;
            if (ch1_hit) begin
                if (ch1_seen && gap > max_gap) max_gap = gap;
                gap      = 0;
                ch1_seen = 1'b1;
                ch1_hits++;
            end
        end
    endtask

    // One clock: drive, sample/check at negedge, record acceptances, advance auto streams.
    task automatic cycle();
        drive();
        @(negedge clk);
        monitor();
        acc_q = fu_valid & fu_ready & {NUM_FU{!flush && !rst}};
        if (rst || flush) begin
            for (int i = 0; i < NUM_FU; i++) sbq[i].delete();
        end
        for (int i = 0; i < NUM_FU; i++) begin
            if (acc_q[i]) sbq[i].push_back(in_ent[i]);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_FU; i++) begin
            if (auto_en[i]) begin
                if (acc_q[i]) auto_seq[i]++;
                in_ent[i]   = auto_ent(i, auto_seq[i]);
                in_valid[i] = 1'b1;
            end
        end
    endtask

    task automatic set_auto(input logic [NUM_FU-1:0] mask);
        auto_en = mask;
        for (int i = 0; i < NUM_FU; i++) begin
            in_valid[i] = mask[i];
            if (mask[i]) in_ent[i] = auto_ent(i, auto_seq[i]);
        end
    endtask

    task automatic push_all(input int unsigned seq);
        for (int i = 0; i < NUM_FU; i++) in_ent[i] = auto_ent(i, seq);
        in_valid = '1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic check_drained(input string tag);
        total = 0;
        for (int i = 0; i < NUM_FU; i++) total += sbq[i].size();
        check_eq(tag, total, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        fair_on  = 1'b0;
        ch1_seen = 1'b0;
        gap      = 0;
        max_gap  = 0;
        ch1_hits = 0;
        in_valid = '0;
        auto_en  = '0;
        acc_q    = '0;
        flush    = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < NUM_FU; i++) begin
            in_ent[i]   = '0;
            auto_seq[i] = 0;
        end

        // Reset: not ready while held, all ready and idle afterwards.
        repeat (3) cycle();
        check_eq("rst_ready", obs_ready, 0);
        rst = 1'b0;
        cycle();
        check_eq("post_rst_ready", obs_ready, 64'h1F);
        check_eq("post_rst_valid", obs_valid, 0);
        check_eq("post_rst_stall", obs_stall, 0);

        // Single push on ch3: visible two cycles later on port 0.
        t1_ent    = {5'd7, 6'd12, 5'd4, 32'hDEADBEEF};
        in_ent[3] = t1_ent;
        in_valid  = 5'b01000;
        cycle();
        in_valid = '0;
        cycle();
        check_eq("t1_c1_valid", obs_valid, 0);
        cycle();
        check_eq("t1_c2_valid", obs_valid, 2'b01);
        check_eq("t1_c2_src", obs_src, src_pair(0, 3));
        check_eq("t1_c2_data", obs_p0, t1_ent);
        cycle();
        check_eq("t1_c3_valid", obs_valid, 0);

        // All five channels at once from rr_ptr=0.
        reset_pulse();
        push_all(100);
        cycle();
        base     = obs_stall;
        in_valid = '0;
        cycle();
        check_eq("t2_c1_valid", obs_valid, 0);
        cycle();
        check_eq("t2_c2_valid", obs_valid, 2'b11);
        check_eq("t2_c2_src", obs_src, src_pair(1, 0));
        cycle();
        check_eq("t2_c3_valid", obs_valid, 2'b11);
        check_eq("t2_c3_src", obs_src, src_pair(3, 2));
        cycle();
        check_eq("t2_c4_valid", obs_valid, 2'b01);
        check_eq("t2_c4_src", obs_src, src_pair(0, 4));
        check_eq("t2_stall", obs_stall, base + 32'd2);
        cycle();
        check_eq("t2_c5_valid", obs_valid, 0);

        // Saturated traffic: ch1 must be served at least every third cycle.
        reset_pulse();
        set_auto(5'b11111);
        repeat (4) cycle();
        fair_on = 1'b1;
        repeat (30) cycle();
        fair_on = 1'b0;
        check_eq("t3_gap", max_gap <= 3, 1'b1);
        check_eq("t3_hits", ch1_hits >= 8, 1'b1);
        set_auto('0);
        repeat (10) cycle();
        check_drained("t3_drain");

        // DEPTH backpressure on ch0 with ports busy serving ch1..ch4.
        reset_pulse();
        set_auto(5'b11110);
        cycle();
        t4_vals[0] = auto_ent(0, 300);
        t4_vals[1] = auto_ent(0, 301);
        t4_vals[2] = auto_ent(0, 302);
        rdy_hist   = '0;
        idx        = 0;
        for (int it = 0; it < 12 && idx < 3; it++) begin
            in_valid[0] = 1'b1;
            in_ent[0]   = t4_vals[idx];
            cycle();
            if (it < 4) rdy_hist[it] = obs_ready[0];
            if (acc_q[0]) idx++;
        end
        in_valid[0] = 1'b0;
        check_eq("t4_accepted", idx, 3);
        check_eq("t4_ready_seq", rdy_hist, 4'b1011);
        set_auto('0);
        repeat (12) cycle();
        check_drained("t4_drain");

        // Flush with ch0..ch2 loaded; a push presented during flush is dropped.
        reset_pulse();
        for (int i = 0; i < 3; i++) in_ent[i] = auto_ent(i, 200);
        in_valid = 5'b00111;
        cycle();
        base = obs_stall;
        for (int i = 0; i < 3; i++) in_ent[i] = auto_ent(i, 201);
        cycle();
        in_valid  = 5'b01000;
        in_ent[3] = auto_ent(3, 202);
        flush     = 1'b1;
        cycle();
        check_eq("t5_flush_valid", obs_valid, 0);
        flush    = 1'b0;
        in_valid = '0;
        cycle();
        check_eq("t5_after_valid", obs_valid, 0);
        check_eq("t5_after_ready", obs_ready, 64'h1F);
        check_eq("t5_stall_kept", obs_stall, base + 32'd1);
        repeat (4) cycle();
        push_all(210);
        cycle();
        in_valid = '0;
        cycle();
        cycle();
        check_eq("t5_rr_valid", obs_valid, 2'b11);
        check_eq("t5_rr_src", obs_src, src_pair(3, 2));
        repeat (4) cycle();
        check_drained("t5_drain");

        // Reset in the middle of saturated traffic.
        set_auto(5'b11111);
        repeat (8) cycle();
        rst = 1'b1;
        cycle();
        check_eq("t6_rst_ready", obs_ready, 0);
        set_auto('0);
        cycle();
        check_eq("t6_rst_valid", obs_valid, 0);
        check_eq("t6_rst_stall", obs_stall, 0);
        rst = 1'b0;
        cycle();
        check_eq("t6_valid", obs_valid, 0);
        check_eq("t6_src", obs_src, 0);
        check_eq("t6_p0", obs_p0, 0);
        check_eq("t6_stall", obs_stall, 0);
        check_eq("t6_ready", obs_ready, 64'h1F);
        push_all(400);
        cycle();
        in_valid = '0;
        cycle();
        cycle();
        check_eq("t6_rr_src", obs_src, src_pair(1, 0));
        repeat (4) cycle();
        check_drained("t6_drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
